// File: rtl/perst_seq_if.sv
// Handshake bundle between the PCIe reset sequencer and its environment.
// Status inputs come in, and reset/status outputs go out.
interface perst_seq_if;
    logic       perst_n;
    logic       pll_locked;
    logic       link_up;
    logic       sw_reset_req;
    logic       core_rst;
    logic       user_rst;
    logic       link_fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    modport master (
        output perst_n, pll_locked, link_up, sw_reset_req,
        input  core_rst, user_rst, link_fault, state, retry_cnt
    );

    modport slave (
        input  perst_n, pll_locked, link_up, sw_reset_req,
        output core_rst, user_rst, link_fault, state, retry_cnt
    );
endinterface

// File: rtl/perst_seq_ctrl.sv
// PCIe fundamental-reset sequencer: holds the core in reset, waits for PLL lock and
// link-up, and retries a bounded number of times after a link timeout.
//
// state     | meaning
// RST       | perst_n asserted or power-on; everything held in reset
// HOLD      | perst_n released, core held in reset for HOLD_CYCLES
// WAIT_PLL  | waiting for pll_locked
// WAIT_LINK | core out of reset, waiting up to LINK_TIMEOUT cycles for link_up
// ACTIVE    | link up, user logic released
// FAULT     | link timeout; back-off of HOLD_CYCLES, then retry or park
module perst_seq_ctrl #(
    parameter int HOLD_CYCLES  = 16,
    parameter int LINK_TIMEOUT = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    perst_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_PLL  = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             fault_q, fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fault_d = fault_q;
        if (!bus.perst_n) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
            fault_d = 1'b0;
        end else if (state_q > ST_FAULT) begin
            state_d = ST_RST;
            cnt_d   = '0;
        end else if (bus.sw_reset_req && state_q != ST_RST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_PLL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_PLL: begin
                    if (bus.pll_locked) begin
                        state_d = ST_WAIT_LINK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LINK: begin
                    // link_up on the terminal cycle still counts as success
                    if (bus.link_up) begin
                        state_d = ST_ACTIVE;
                        fault_d = 1'b0;
                    end else if (cnt_q == LINK_LAST) begin
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.pll_locked) begin
                        state_d = ST_WAIT_PLL;
                        cnt_d   = '0;
                    end else if (!bus.link_up) begin
                        state_d = ST_WAIT_LINK;
                        cnt_d   = '0;
                    end
                end
                ST_FAULT: begin
                    // Counter parks at HOLD_LAST once retries are exhausted
                    if (cnt_q == HOLD_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_WAIT_PLL;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.core_rst   = !(state_q == ST_WAIT_LINK || state_q == ST_ACTIVE);
    assign bus.user_rst   = (state_q != ST_ACTIVE);
    assign bus.link_fault = fault_q;
    assign bus.retry_cnt  = retry_q;
endmodule

// File: tb/tb_perst_seq_ctrl.sv
// Directed bench for perst_seq_ctrl with HOLD_CYCLES=8, LINK_TIMEOUT=32, MAX_RETRY=2.
// Each vector holds inputs for N cycles, then checks all outputs.
module tb_perst_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    perst_seq_if bus ();

    perst_seq_ctrl #(
        .HOLD_CYCLES (8),
        .LINK_TIMEOUT(32),
        .MAX_RETRY   (2),
        .CNT_W       (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       perst_n;
        logic       pll;
        logic       link;
        logic       sw;
        int         n;
        logic [2:0] st;
        logic       core;
        logic       user;
        logic       fault;
        logic [3:0] retry;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic p, input logic pl, input logic l, input logic s, input int n,
                       input logic [2:0] st, input logic c, input logic u, input logic f,
                       input logic [3:0] r);
        vec_t v;
        v.perst_n = p; v.pll = pl; v.link = l; v.sw = s; v.n = n;
        v.st = st; v.core = c; v.user = u; v.fault = f; v.retry = r;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] st, input logic c, input logic u,
                             input logic f, input logic [3:0] r);
        cmp("state", idx, int'(bus.state), int'(st));
        cmp("core_rst", idx, int'(bus.core_rst), int'(c));
        cmp("user_rst", idx, int'(bus.user_rst), int'(u));
        cmp("link_fault", idx, int'(bus.link_fault), int'(f));
        cmp("retry_cnt", idx, int'(bus.retry_cnt), int'(r));
    endtask

    initial begin
        // perst pll link sw  n   state core user fault retry
        add(0, 1, 0, 0, 1,  3'd0, 1, 1, 0, 0);   // RST held
        add(1, 1, 0, 0, 1,  3'd1, 1, 1, 0, 0);   // edge T: HOLD
        add(1, 1, 0, 0, 7,  3'd1, 1, 1, 0, 0);   // still HOLD at T+7
        add(1, 1, 0, 0, 1,  3'd2, 1, 1, 0, 0);   // T+8 WAIT_PLL
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 0, 0);   // T+9 core_rst falls
        add(1, 1, 0, 0, 6,  3'd3, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1,  3'd4, 0, 0, 0, 0);   // T+16 ACTIVE
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 0, 0);   // link drop
        add(1, 1, 1, 0, 1,  3'd4, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  3'd2, 1, 1, 0, 0);   // pll loss beats link loss
        add(1, 1, 1, 0, 1,  3'd3, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1,  3'd4, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1,  3'd1, 1, 1, 0, 0);   // sw reset in ACTIVE
        add(1, 1, 1, 0, 8,  3'd2, 1, 1, 0, 0);
        add(1, 1, 1, 0, 2,  3'd4, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  3'd0, 1, 1, 0, 0);   // perst_n beats sw_reset_req
        add(1, 1, 0, 0, 1,  3'd1, 1, 1, 0, 0);
        add(1, 1, 0, 0, 8,  3'd2, 1, 1, 0, 0);
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 0, 0);
        add(1, 1, 0, 0, 31, 3'd3, 0, 1, 0, 0);   // counter at 31
        add(1, 1, 0, 0, 1,  3'd5, 1, 1, 1, 0);   // timeout -> FAULT
        add(1, 1, 0, 0, 7,  3'd5, 1, 1, 1, 0);
        add(1, 1, 0, 0, 1,  3'd2, 1, 1, 1, 1);   // retry 1
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 1, 1);
        add(1, 1, 0, 0, 32, 3'd5, 1, 1, 1, 1);
        add(1, 1, 0, 0, 8,  3'd2, 1, 1, 1, 2);   // retry 2
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 1, 2);
        add(1, 1, 0, 0, 32, 3'd5, 1, 1, 1, 2);
        add(1, 1, 0, 0, 8,  3'd5, 1, 1, 1, 2);   // exhausted: parked
        add(1, 1, 0, 0, 20, 3'd5, 1, 1, 1, 2);
        add(1, 1, 0, 1, 1,  3'd1, 1, 1, 1, 0);   // sw recovery
        add(1, 1, 0, 0, 8,  3'd2, 1, 1, 1, 0);
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 1, 0);
        add(1, 1, 1, 0, 1,  3'd4, 0, 0, 0, 0);   // ACTIVE clears fault
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 0, 0);
        add(1, 1, 0, 0, 31, 3'd3, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1,  3'd4, 0, 0, 0, 0);   // link_up on counter==31
        add(1, 1, 0, 0, 1,  3'd3, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32, 3'd5, 1, 1, 1, 0);
        add(1, 1, 0, 0, 8,  3'd2, 1, 1, 1, 1);
        add(0, 1, 0, 0, 1,  3'd0, 1, 1, 0, 0);   // perst_n clears fault/retry

        bus.perst_n = 1'b0;
        bus.pll_locked = 1'b1;
        bus.link_up = 1'b0;
        bus.sw_reset_req = 1'b0;
        #12;
        check_all(-1, 3'd0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.perst_n      = vecs[i].perst_n;
            bus.pll_locked   = vecs[i].pll;
            bus.link_up      = vecs[i].link;
            bus.sw_reset_req = vecs[i].sw;
            repeat (vecs[i].n) begin
                @(posedge clk);
                #1;
                bus.sw_reset_req = 1'b0;
            end
            check_all(i, vecs[i].st, vecs[i].core, vecs[i].user, vecs[i].fault, vecs[i].retry);
        end

        // Async rst mid-sequence aborts without a clock edge
        bus.perst_n = 1'b1;
        bus.link_up = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_all(100, 3'd1, 1, 1, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all(101, 3'd0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all(102, 3'd1, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/perst_seq_ctrl.md
PERST_SEQ_CTRL -- requirements
Module: perst_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles core stays in reset after perst_n rises (min 2).
REQ-002 SHALL have parameter LINK_TIMEOUT, default 1024: max cycles to wait for link_up (min 2).
REQ-003 SHALL have parameter MAX_RETRY, default 3: automatic re-tries after link timeout (1..15).
REQ-004 SHALL have parameter CNT_W, default 16: counter width; must hold max(HOLD_CYCLES, LINK_TIMEOUT)-1.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port perst_n  input  1  debounced, clk-synchronous fundamental reset, active low.
REQ-008 SHALL have port pll_locked  input  1  clk-synchronous PLL lock status.
REQ-009 SHALL have port link_up  input  1  clk-synchronous link-up status.
REQ-010 SHALL have port sw_reset_req  input  1  single-cycle software reset request.
REQ-011 SHALL have port core_rst  output  1  reset to PCIe core, active high.
REQ-012 SHALL have port user_rst  output  1  reset to user logic, active high.
REQ-013 SHALL have port link_fault  output  1  sticky link-timeout indication.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port retry_cnt  output  4  retries consumed since last clear.

Function
REQ-016 SHALL implement states RST=0, HOLD=1, WAIT_PLL=2, WAIT_LINK=3, ACTIVE=4, FAULT=5; codes 6-7 unreachable, SHALL return to RST next cycle if ever entered.
REQ-017 SHALL decode all outputs from registers only (no combinational input-to-output path).
REQ-018 SHALL drive core_rst=1 in RST, HOLD, WAIT_PLL, FAULT; 0 in WAIT_LINK, ACTIVE.
REQ-019 SHALL drive user_rst=0 only in ACTIVE.
REQ-020 SHALL, with perst_n=0 sampled in any state, enter RST next cycle, clear counter, retry_cnt and link_fault; highest priority.
REQ-021 SHALL, with sw_reset_req=1 and perst_n=1 in any state other than RST, enter HOLD with counter=0 and clear retry_cnt; second priority; ignored in RST.
REQ-022 SHALL move RST->HOLD when perst_n=1, counter=0.
REQ-023 SHALL increment counter in HOLD and move to WAIT_PLL on the cycle counter==HOLD_CYCLES-1 (exactly HOLD_CYCLES cycles in HOLD).
REQ-024 SHALL move WAIT_PLL->WAIT_LINK, counter=0, when pll_locked=1; wait indefinitely otherwise.
REQ-025 SHALL in WAIT_LINK move to ACTIVE when link_up=1; else increment counter and move to FAULT when counter==LINK_TIMEOUT-1; link_up wins if both coincide.
REQ-026 SHALL set link_fault=1 on entering FAULT; clear it on entering ACTIVE or per REQ-020.
REQ-027 SHALL in ACTIVE: pll_locked=0 -> WAIT_PLL; else link_up=0 -> WAIT_LINK, counter=0; pll_locked loss has priority.
REQ-028 SHALL in FAULT count HOLD_CYCLES cycles, then if retry_cnt<MAX_RETRY increment retry_cnt and enter WAIT_PLL; if retry_cnt==MAX_RETRY remain in FAULT until REQ-020/REQ-021.
REQ-029 SHALL keep retry_cnt saturating; never wrap.

Reset
REQ-030 SHALL, while rst=1, force state=RST, counter=0, core_rst=1, user_rst=1, link_fault=0, retry_cnt=0 asynchronously.
REQ-031 SHALL begin normal sequencing on the first clk edge after rst deasserts; rst mid-sequence aborts to RST immediately.

Verification (HOLD_CYCLES=8, LINK_TIMEOUT=32, MAX_RETRY=2)
REQ-032 SHALL cover bring-up: perst_n rises edge T, pll_locked=1, link_up at T+15 -> core_rst falls at T+9, user_rst falls at T+16, state=4.
REQ-033 SHALL cover timeout/retry: link_up never -> link_fault=1 after 32 cycles in WAIT_LINK, retry_cnt 1 then 2, then FAULT held, core_rst=1.
REQ-034 SHALL cover recovery: after REQ-033, sw_reset_req pulse -> HOLD, retry_cnt=0; link_up then -> ACTIVE, link_fault=0.
REQ-035 SHALL cover link drop in ACTIVE: link_up=0 one cycle -> state=3, user_rst=1, core_rst=0 next cycle.
REQ-036 SHALL cover priority: perst_n=0 and sw_reset_req=1 same cycle in ACTIVE -> RST, all resets 1, retry_cnt=0.
REQ-037 SHALL cover boundary: link_up rises on counter==31 cycle -> ACTIVE, link_fault stays 0.
